usart_rx_param: RTL and testbench

//   Parametrised asynchronous serial receiver for the USART controller path. It is the

---
 rtl/usart_rx_param.sv | 186 ++++++++++++++++++
 tb/tb_usart_rx_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_rx_param.sv
// Parametrised UART receiver: deserialises rx, checks parity/stop bits, holds one word with flags.
// Word loads one cycle after its last stop sample; a frame completing into a full, unaccepted buffer is dropped with an overrun pulse.
module usart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   fe_q, fe_d;
  logic                   pe_q, pe_d;
  logic                   bit_tick;
  logic                   frame_done, done_fe;

  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, ofe_q, ope_q, ovr_q;

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
    end
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    frame_done = 1'b0;
    done_fe    = fe_q;
    case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          state_d = S_START;
          cnt_d   = '0;
          par_d   = 1'b0;
          fe_d    = 1'b0;
          pe_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rxs;
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAR: begin
        if (bit_tick) begin
          cnt_d   = '0;
          pe_d    = (PARITY == 1) ? ~(par_q ^ rxs) : (par_q ^ rxs);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (!rxs) fe_d = 1'b1;
          if (bit_idx_q == BIT_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            done_fe    = fe_q | ~rxs;
            // A low final stop bit means a break: park until the line returns high.
            state_d    = rxs ? S_IDLE : S_BRK;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BRK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ofe_q   <= 1'b0;
      ope_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (frame_done) begin
        if (valid_q && !rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          ofe_q   <= done_fe;
          ope_q   <= pe_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
        ofe_q   <= 1'b0;
        ope_q   <= 1'b0;
      end
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ofe_q;
  assign parity_err = ope_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_usart_rx_param.sv
// Bench for usart_rx_param: an 8N1 instance and an 8E2 instance, each checked against a word-level scoreboard.
module tb_usart_rx_param;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rx, rx_ready;
  logic [7:0] rx_data [2];
  logic [1:0] rx_valid, frame_err, parity_err, overrun, busy;

  always #5 clk = ~clk;

  usart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_n (
    .clk(clk), .reset(reset), .rx(rx[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]),
    .overrun(overrun[0]), .busy(busy[0]));

  usart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(3)) u_e (
    .clk(clk), .reset(reset), .rx(rx[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]),
    .overrun(overrun[1]), .busy(busy[1]));

  // Scoreboard: words the line carried, in order, with the flags they must arrive with.
  logic [7:0] e_dat [2][64];
  logic       e_fe  [2][64];
  logic       e_pe  [2][64];
  int         wr [2], rd [2];
  logic [7:0] m_dat [2];
  logic       m_fe [2], m_pe [2];
  logic [7:0] last_dat [2];
  logic       last_fe [2], last_pe [2];
  int         exp_ovr [2], ovr_seen [2], vcycles [2];
  logic [1:0] pv, pr, pov;
  int         n_chk, n_fail;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int i, input logic [7:0] d, input logic fe, input logic pe);
    e_dat[i][wr[i][5:0]] = d;
    e_fe[i][wr[i][5:0]]  = fe;
    e_pe[i][wr[i][5:0]]  = pe;
    wr[i]++;
  endtask

  // Instance 0 is 8N1, instance 1 is 8 data + even parity + 2 stop bits.
  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input int extra_low, input bit expect_it);
    int nst;
    logic fe, pe;
    nst = (i == 1) ? 2 : 1;
    fe  = (i == 1) ? ~&stops : ~stops[0];
    pe  = (i == 1) ? ^{d, pbit} : 1'b0;
    if (expect_it) expect_word(i, d, fe, pe);
    rx[i] = 1'b0;
    hold(CPB);
    for (int b = 0; b < 8; b++) begin
      rx[i] = d[b];
      hold(CPB);
    end
    if (i == 1) begin
      rx[i] = pbit;
      hold(CPB);
    end
    for (int s = 0; s < nst; s++) begin
      rx[i] = stops[s];
      hold(CPB);
    end
    if (extra_low > 0) begin
      rx[i] = 1'b0;
      hold(extra_low);
    end
    rx[i] = 1'b1;
    hold(2 * CPB);
  endtask

  initial begin
    int vc, oc, i, extra;
    logic [7:0] d;
    logic [1:0] stops;
    logic pbit;
    reset = 1'b0;
    rx = 2'b11;
    rx_ready = 2'b11;
    n_chk = 0;
    n_fail = 0;
    pv = '0; pr = '0; pov = '0;
    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rd[k] = 0; exp_ovr[k] = 0; ovr_seen[k] = 0; vcycles[k] = 0;
      m_dat[k] = '0; m_fe[k] = 1'b0; m_pe[k] = 1'b0;
      last_dat[k] = '0; last_fe[k] = 1'b0; last_pe[k] = 1'b0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          if (!reset) begin
            chk_b("reset_valid", rx_valid[k], 1'b0);
            chk_b("reset_busy", busy[k], 1'b0);
            chk_b("reset_overrun", overrun[k], 1'b0);
            chk_v("reset_data", 32'(rx_data[k]), 32'h0);
            rd[k] = wr[k];
            m_dat[k] = '0; m_fe[k] = 1'b0; m_pe[k] = 1'b0;
          end else begin
            if (rx_valid[k] && !(pv[k] && !pr[k])) begin
              chk_b("word_expected", (wr[k] != rd[k]), 1'b1);
              if (wr[k] != rd[k]) begin
                m_dat[k] = e_dat[k][rd[k][5:0]];
                m_fe[k]  = e_fe[k][rd[k][5:0]];
                m_pe[k]  = e_pe[k][rd[k][5:0]];
                rd[k]++;
              end
              last_dat[k] = rx_data[k];
              last_fe[k]  = frame_err[k];
              last_pe[k]  = parity_err[k];
            end
            if (rx_valid[k]) vcycles[k]++;
            if (overrun[k]) begin
              chk_b("overrun_single_cycle", pov[k], 1'b0);
              ovr_seen[k]++;
            end
            chk_v("rx_data", 32'(rx_data[k]), 32'(m_dat[k]));
            chk_b("frame_err", frame_err[k], rx_valid[k] & m_fe[k]);
            chk_b("parity_err", parity_err[k], rx_valid[k] & m_pe[k]);
          end
          pv[k]  = reset ? rx_valid[k] : 1'b0;
          pr[k]  = rx_ready[k];
          pov[k] = overrun[k];
        end
      end
    join_none

    @(posedge clk); #1;
    hold(3);
    reset = 1'b1;
    hold(5);

    // 8N1 0x0A with consumer ready: one-cycle valid pulse, clean flags.
    vc = vcycles[0];
    send_frame(0, 8'h0A, 1'b0, 2'b11, 0, 1);
    chk_v("t1_valid_cycles", vcycles[0] - vc, 1);
    chk_v("t1_data", 32'(last_dat[0]), 32'h0A);
    chk_b("t1_frame_err", last_fe[0], 1'b0);
    chk_b("t1_parity_err", last_pe[0], 1'b0);

    // Glitch shorter than half a bit is rejected at mid-start.
    vc = vcycles[0];
    rx[0] = 1'b0;
    hold(4);
    chk_b("t2_busy_in_start", busy[0], 1'b1);
    rx[0] = 1'b1;
    hold(12);
    chk_b("t2_busy_cleared", busy[0], 1'b0);
    chk_v("t2_no_word", vcycles[0] - vc, 0);

    // Even parity: 0x0A has two ones, so parity bit 1 is wrong and 0 is right.
    send_frame(1, 8'h0A, 1'b1, 2'b11, 0, 1);
    chk_v("t3_data", 32'(last_dat[1]), 32'h0A);
    chk_b("t3_parity_err_set", last_pe[1], 1'b1);
    send_frame(1, 8'h0A, 1'b0, 2'b11, 0, 1);
    chk_b("t3_parity_err_clear", last_pe[1], 1'b0);

    // Break: low stop then line held low; exactly one flagged word, then a clean frame.
    vc = vcycles[0];
    send_frame(0, 8'h0A, 1'b0, 2'b00, 3 * CPB, 1);
    chk_v("t4_one_word", vcycles[0] - vc, 1);
    chk_b("t4_frame_err", last_fe[0], 1'b1);
    chk_v("t4_data", 32'(last_dat[0]), 32'h0A);
    send_frame(0, 8'h55, 1'b0, 2'b11, 0, 1);
    chk_v("t4_next_data", 32'(last_dat[0]), 32'h55);
    chk_b("t4_next_clean", last_fe[0], 1'b0);

    // Overrun: second frame lands on an unaccepted word and is dropped.
    oc = ovr_seen[0];
    rx_ready[0] = 1'b0;
    send_frame(0, 8'h0A, 1'b0, 2'b11, 0, 1);
    send_frame(0, 8'h55, 1'b0, 2'b11, 0, 0);
    exp_ovr[0]++;
    chk_v("t5_overrun_pulses", ovr_seen[0] - oc, 1);
    chk_b("t5_valid_held", rx_valid[0], 1'b1);
    chk_v("t5_data_held", 32'(rx_data[0]), 32'h0A);
    rx_ready[0] = 1'b1;
    hold(1);
    chk_b("t5_valid_falls", rx_valid[0], 1'b0);
    chk_v("t5_data_kept", 32'(rx_data[0]), 32'h0A);

    // Reset in the middle of a data phase clears everything immediately.
    rx_ready[0] = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 2'b11, 0, 1);
    rx[0] = 1'b0;
    hold(CPB);
    rx[0] = 1'b0; hold(CPB);
    rx[0] = 1'b1; hold(CPB);
    rx[0] = 1'b0; hold(CPB / 2);
    reset = 1'b0;
    #1;
    chk_b("t6_valid_async", rx_valid[0], 1'b0);
    chk_b("t6_busy_async", busy[0], 1'b0);
    chk_v("t6_data_async", 32'(rx_data[0]), 32'h0);
    rx[0] = 1'b1;
    hold(3);
    reset = 1'b1;
    rx_ready[0] = 1'b1;
    hold(2 * CPB);
    send_frame(0, 8'hA5, 1'b0, 2'b11, 0, 1);
    chk_v("t6_data_after", 32'(last_dat[0]), 32'hA5);
    chk_b("t6_fe_after", last_fe[0], 1'b0);

    // Randomised frames on both formats, including bad parity and bad/held stop bits.
    rx_ready = 2'b11;
    for (int k = 0; k < 30; k++) begin
      i     = int'($urandom_range(0, 1));
      d     = 8'($urandom);
      pbit  = 1'($urandom);
      stops = 2'b11;
      if ($urandom_range(0, 5) == 0) stops[$urandom_range(0, 1)] = 1'b0;
      extra = ((i == 1) ? stops[1] : stops[0]) ? 0 : int'($urandom_range(0, 40));
      send_frame(i, d, pbit, stops, extra, 1);
    end

    for (int k = 0; k < 2; k++) begin
      chk_v("all_words_delivered", rd[k], wr[k]);
      chk_v("overrun_count", ovr_seen[k], exp_ovr[k]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
